// File: rtl/membus_pkg.sv
// Shared types and constants for the two-master RAM arbiter.
package membus_pkg;

  // Arbiter FSM state encoding.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Master ids; also used as the grant/last encodings.
  localparam logic M_CPU = 1'b0;
  localparam logic M_AUX = 1'b1;

endpackage

// File: rtl/membus_arb_if.sv
// Bundle of both master handshakes plus the RAM-side port of the arbiter.
interface membus_arb_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 32
);

  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_ack;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_ack;
  logic [DW-1:0] m1_rdata;

  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  logic          busy;

  // Environment side: requesters and the RAM itself.
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_ack, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_ack, m1_rdata,
    input  ram_addr, ram_we, ram_wdata,
    output ram_rdata,
    input  busy
  );

  // Arbiter side.
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_ack, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_ack, m1_rdata,
    output ram_addr, ram_we, ram_wdata,
    input  ram_rdata,
    output busy
  );

endinterface

// File: rtl/membus_arb_rr_pick2.sv
// Combinational two-input round-robin picker.
module rr_pick2
  import membus_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       valid_o,
  output logic       id_o
);

  // On a tie the master that was not granted last wins; a lone requester always wins.
  always_comb begin
    valid_o = |req_i;
    if (req_i == 2'b11) begin
      id_o = ~last_i;
    end else begin
      id_o = req_i[1] ? M_AUX : M_CPU;
    end
  end

endmodule

// File: rtl/membus_arb.sv
// Two-master round-robin arbiter in front of a single-port asynchronous-read RAM.
module membus_arb
  import membus_pkg::*;
#(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 32
) (
  input logic         clk,
  input logic         reset,
  membus_arb_if.slave bus
);

  state_e        state_q, state_d;
  logic          gnt_q, gnt_d;
  logic          last_q, last_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic          ram_we_q, ram_we_d;
  logic [DW-1:0] ram_wdata_q, ram_wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic [1:0]    req_elig;
  logic          pick_valid;
  logic          pick_id;

  // The master being acked in DONE still holds req from the finished access; mask it.
  always_comb begin
    req_elig = {bus.m1_req, bus.m0_req};
    if (state_q == ST_DONE) begin
      req_elig[gnt_q] = 1'b0;
    end
  end

  rr_pick2 u_pick (
    .req_i   (req_elig),
    .last_i  (last_q),
    .valid_o (pick_valid),
    .id_o    (pick_id)
  );

  // Next-state logic: arbitrate in IDLE/DONE, capture read data at the end of ACCESS.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
    rdata_d     = rdata_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (pick_valid) begin
          state_d = ST_ACCESS;
          gnt_d   = pick_id;
          last_d  = pick_id;
          if (pick_id == M_AUX) begin
            ram_addr_d  = bus.m1_addr;
            ram_wdata_d = bus.m1_wdata;
            ram_we_d    = bus.m1_we;
          end else begin
            ram_addr_d  = bus.m0_addr;
            ram_wdata_d = bus.m0_wdata;
            ram_we_d    = bus.m0_we;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        rdata_d = bus.ram_rdata;
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and RAM-side registers; reset aborts any access in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      gnt_q       <= M_CPU;
      last_q      <= M_AUX;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  // Outputs decoded from registered state.
  always_comb begin
    bus.m0_ack    = (state_q == ST_DONE) && (gnt_q == M_CPU);
    bus.m1_ack    = (state_q == ST_DONE) && (gnt_q == M_AUX);
    bus.m0_rdata  = rdata_q;
    bus.m1_rdata  = rdata_q;
    bus.ram_addr  = ram_addr_q;
    bus.ram_we    = ram_we_q;
    bus.ram_wdata = ram_wdata_q;
    bus.busy      = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_membus_arb.sv
// Self-checking bench for membus_arb: directed scenarios plus random two-master traffic.
module tb_membus_arb;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  membus_arb_if #(.AW(8), .DW(32)) bus ();

  membus_arb #(.AW(8), .DW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // RAM model: asynchronous read, synchronous write; preload port for the bench.
  logic [31:0] mem [256];
  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [31:0] pl_data;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
  end
  assign bus.ram_rdata = mem[bus.ram_addr];

  // Reference memory contents as seen by completed transactions, in ack order.
  logic [31:0] ref_mem [256];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_masters();
    bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    ref_mem[a] = d;
    step();
    pl_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    int acks;
    do_reset();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %b want 0", bus.busy); end
    total++; if ({bus.m0_ack, bus.m1_ack, bus.ram_we} !== 3'b000) begin
      bad++; $display("FAIL rst_ack_we got %b want 000", {bus.m0_ack, bus.m1_ack, bus.ram_we});
    end
    total++; if ({bus.ram_addr, bus.ram_wdata, bus.m0_rdata} !== '0) begin
      bad++; $display("FAIL rst_regs got %h %h %h want 0", bus.ram_addr, bus.ram_wdata, bus.m0_rdata);
    end
    // Write to 0x10, then reset in the middle of its ACCESS cycle.
    bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 8'h10; bus.m0_wdata = 32'hA5A5_A5A5;
    step();
    total++; if ({bus.ram_we, bus.ram_addr} !== {1'b1, 8'h10}) begin
      bad++; $display("FAIL rst_pre_access got we=%b addr=%h want we=1 addr=10", bus.ram_we, bus.ram_addr);
    end
    #2 reset = 1'b1;
    #1;
    total++; if ({bus.ram_we, bus.busy, bus.m0_ack, bus.m1_ack, bus.ram_addr, bus.ram_wdata, bus.m0_rdata}
                 !== '0) begin
      bad++; $display("FAIL rst_abort_outputs got we=%b busy=%b addr=%h wdata=%h want all 0",
                      bus.ram_we, bus.busy, bus.ram_addr, bus.ram_wdata);
    end
    idle_masters();
    acks = 0;
    repeat (3) begin step(); if (bus.m0_ack || bus.m1_ack) acks++; end
    reset = 1'b0;
    repeat (3) begin step(); if (bus.m0_ack || bus.m1_ack) acks++; end
    total++; if (acks !== 0) begin bad++; $display("FAIL rst_no_ack got %0d acks want 0", acks); end
    // First tie after reset goes to master 0.
    bus.m0_req = 1'b1; bus.m0_addr = 8'h01;
    bus.m1_req = 1'b1; bus.m1_addr = 8'h02;
    step();
    step();
    total++; if ({bus.m0_ack, bus.m1_ack} !== 2'b10) begin
      bad++; $display("FAIL rst_first_tie got m0_ack=%b m1_ack=%b want 1 0", bus.m0_ack, bus.m1_ack);
    end
    bus.m0_req = 1'b0;
    step();
    step();
    idle_masters();
    step();
  endtask

  task automatic test_single_read();
    preload(8'h05, 32'hDEAD_BEEF);
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 8'h05;
    step();
    total++; if (bus.m0_ack !== 1'b0) begin bad++; $display("FAIL rd_early_ack got %b want 0", bus.m0_ack); end
    step();
    total++; if ({bus.m0_ack, bus.m1_ack} !== 2'b10) begin
      bad++; $display("FAIL rd_ack got m0=%b m1=%b want 1 0", bus.m0_ack, bus.m1_ack);
    end
    total++; if (bus.m0_rdata !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL rd_data got %h want deadbeef", bus.m0_rdata);
    end
    idle_masters();
    step();
    total++; if (bus.m0_ack !== 1'b0) begin bad++; $display("FAIL rd_ack_pulse got %b want 0", bus.m0_ack); end
    step();
  endtask

  task automatic test_write_read();
    int we_cnt;
    int acked;
    bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 8'h20; bus.m1_wdata = 32'h1234_5678;
    we_cnt = 0; acked = 0;
    repeat (4) begin
      step();
      if (bus.ram_we) we_cnt++;
      if (bus.m1_ack) begin acked++; bus.m1_req = 1'b0; end
    end
    ref_mem[8'h20] = 32'h1234_5678;
    total++; if (we_cnt !== 1) begin bad++; $display("FAIL wr_we_cycles got %0d want 1", we_cnt); end
    total++; if (acked !== 1) begin bad++; $display("FAIL wr_ack got %0d want 1", acked); end
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 8'h20;
    step();
    step();
    total++; if ({bus.m1_ack, bus.m1_rdata} !== {1'b1, 32'h1234_5678}) begin
      bad++; $display("FAIL wr_readback got ack=%b data=%h want 1 12345678", bus.m1_ack, bus.m1_rdata);
    end
    idle_masters();
    step();
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus.m0_req = 1'b1; bus.m0_addr = 8'h01;
    bus.m1_req = 1'b1; bus.m1_addr = 8'h02;
    step();
    step();
    total++; if ({bus.m0_ack, bus.m1_ack, bus.m0_rdata} !== {2'b10, ref_mem[8'h01]}) begin
      bad++; $display("FAIL sim_first got m0=%b m1=%b data=%h want 1 0 %h",
                      bus.m0_ack, bus.m1_ack, bus.m0_rdata, ref_mem[8'h01]);
    end
    bus.m0_req = 1'b0;
    step();
    total++; if ({bus.busy, bus.m1_ack} !== 2'b10) begin
      bad++; $display("FAIL sim_no_idle got busy=%b m1_ack=%b want 1 0", bus.busy, bus.m1_ack);
    end
    step();
    total++; if ({bus.m1_ack, bus.m1_rdata} !== {1'b1, ref_mem[8'h02]}) begin
      bad++; $display("FAIL sim_second got ack=%b data=%h want 1 %h", bus.m1_ack, bus.m1_rdata, ref_mem[8'h02]);
    end
    idle_masters();
    step();
  endtask

  task automatic test_sustained();
    int   acks;
    int   busy_low;
    logic exp_id;
    logic got;
    logic [31:0] got_d;
    do_reset();
    bus.m0_req = 1'b1; bus.m0_addr = 8'h03;
    bus.m1_req = 1'b1; bus.m1_addr = 8'h04;
    acks = 0; busy_low = 0;
    exp_id = 1'b0;  // last resets to master 1, so master 0 wins the first tie
    for (int c = 0; c < 40 && acks < 8; c++) begin
      step();
      if (!bus.busy) busy_low++;
      if (bus.m0_ack || bus.m1_ack) begin
        got   = bus.m1_ack;
        got_d = got ? bus.m1_rdata : bus.m0_rdata;
        total++;
        if (got !== exp_id || got_d !== ref_mem[exp_id ? 8'h04 : 8'h03]) begin
          bad++; $display("FAIL rr_grant%0d got id=%b data=%h want id=%b data=%h", acks, got, got_d,
                          exp_id, ref_mem[exp_id ? 8'h04 : 8'h03]);
        end
        exp_id = ~exp_id;
        acks++;
      end
    end
    total++; if (acks !== 8) begin bad++; $display("FAIL rr_count got %0d acks want 8", acks); end
    total++; if (busy_low !== 0) begin bad++; $display("FAIL rr_busy got %0d idle cycles want 0", busy_low); end
    idle_masters();
    step();
    step();
  endtask

  task automatic test_stability();
    preload(8'hFF, 32'h0BAD_F00D);
    preload(8'h07, 32'h5555_AAAA);
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 8'h07;
    step();
    bus.m0_addr = 8'hFF;
    #1;
    total++; if (bus.ram_addr !== 8'h07) begin
      bad++; $display("FAIL stab_addr got %h want 07", bus.ram_addr);
    end
    step();
    total++; if ({bus.m0_ack, bus.m0_rdata} !== {1'b1, 32'h5555_AAAA}) begin
      bad++; $display("FAIL stab_data got ack=%b data=%h want 1 5555aaaa", bus.m0_ack, bus.m0_rdata);
    end
    idle_masters();
    step();
  endtask

  // Random independent traffic from both masters; every completion is checked against ref_mem
  // and every request must complete within 4 edges.
  task automatic test_random();
    logic        pend  [2];
    logic        we    [2];
    logic [7:0]  addr  [2];
    logic [31:0] wdata [2];
    int          wait_n[2];
    logic        ack   [2];
    logic [31:0] rd    [2];
    logic        done  [2];
    for (int m = 0; m < 2; m++) begin pend[m] = 1'b0; wait_n[m] = 0; end
    for (int c = 0; c < 400; c++) begin
      step();
      ack[0] = bus.m0_ack; ack[1] = bus.m1_ack;
      rd[0]  = bus.m0_rdata; rd[1] = bus.m1_rdata;
      if (ack[0] && ack[1]) begin
        total++; bad++; $display("FAIL rnd_double_ack at cycle %0d got both want one", c);
      end
      for (int m = 0; m < 2; m++) begin
        done[m] = 1'b0;
        if (ack[m]) begin
          total++;
          if (!pend[m]) begin
            bad++; $display("FAIL rnd_spurious_ack m%0d got ack want none", m);
          end else if (wait_n[m] + 1 > 4) begin
            bad++; $display("FAIL rnd_latency m%0d got %0d edges want <=4", m, wait_n[m] + 1);
          end else if (!we[m] && rd[m] !== ref_mem[addr[m]]) begin
            bad++; $display("FAIL rnd_rdata m%0d addr=%h got %h want %h", m, addr[m], rd[m], ref_mem[addr[m]]);
          end
          if (pend[m] && we[m]) ref_mem[addr[m]] = wdata[m];
          pend[m] = 1'b0;
          done[m] = 1'b1;
        end else if (pend[m]) begin
          wait_n[m]++;
          if (wait_n[m] > 8) begin
            total++; bad++; $display("FAIL rnd_timeout m%0d got no ack after %0d edges want ack", m, wait_n[m]);
            pend[m] = 1'b0;
          end
        end
        if (!pend[m] && !done[m] && $urandom_range(0, 2) != 0) begin
          pend[m]   = 1'b1;
          wait_n[m] = 0;
          we[m]     = $urandom_range(0, 1) == 1;
          addr[m]   = 8'($urandom_range(0, 15));
          wdata[m]  = $urandom;
        end
      end
      bus.m0_req = pend[0]; bus.m0_we = we[0]; bus.m0_addr = addr[0]; bus.m0_wdata = wdata[0];
      bus.m1_req = pend[1]; bus.m1_we = we[1]; bus.m1_addr = addr[1]; bus.m1_wdata = wdata[1];
    end
    idle_masters();
    repeat (4) step();
  endtask

  initial begin
    reset = 1'b1;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    idle_masters();
    for (int i = 0; i < 16; i++) preload(8'(i), $urandom);
    reset = 1'b0;
    test_reset();
    test_single_read();
    test_write_read();
    test_simultaneous();
    test_sustained();
    test_stability();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
